// File: rtl/pc_fetch_unit.sv
// Instruction fetch with a one-entry PC/instruction buffer: hits finish in 1 cycle, misses go to memory.
// Miss latency is 2 cycles plus memory wait cycles. The read request is held stable until MemReadReady.
module pc_fetch_unit #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   FetchStart,
   input  logic [PC_WIDTH-1:0]    CurrentPC,
   input  logic                   Invalidate,
   output logic                   MemReadValid,
   output logic [PC_WIDTH-1:0]    MemReadAddress,
   input  logic                   MemReadReady,
   input  logic [INSTR_WIDTH-1:0] MemReadData,
   output logic [INSTR_WIDTH-1:0] Instruction,
   output logic                   FetchDone,
   output logic                   Busy
);

   typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;

   state_t                 state_q;
   logic                   mem_vld_q;
   logic                   done_q;
   logic                   busy_q;
   logic [PC_WIDTH-1:0]    req_pc_q;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic                   buf_valid_q;
   logic [PC_WIDTH-1:0]    buf_pc_q;
   logic [INSTR_WIDTH-1:0] buf_instr_q;
   logic                   hit;

   // Lookup uses the buffer contents before any same-cycle Invalidate takes effect.
   assign hit = buf_valid_q && (buf_pc_q == CurrentPC);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_vld_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         req_pc_q    <= '0;
         instr_q     <= '0;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (FetchStart) begin
                  req_pc_q <= CurrentPC;
                  busy_q   <= 1'b1;
                  if (hit) begin
                     instr_q <= buf_instr_q;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     mem_vld_q <= 1'b1;
                     state_q   <= REQUEST;
                  end
               end
            end
            REQUEST: begin
               if (MemReadReady) begin
                  instr_q     <= MemReadData;
                  buf_pc_q    <= req_pc_q;
                  buf_instr_q <= MemReadData;
                  buf_valid_q <= 1'b1;
                  mem_vld_q   <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               mem_vld_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
         // Placed last so it overrides a same-cycle buffer fill.
         if (Invalidate) buf_valid_q <= 1'b0;
      end
   end

   assign MemReadValid   = mem_vld_q;
   assign MemReadAddress = req_pc_q;
   assign Instruction    = instr_q;
   assign FetchDone      = done_q;
   assign Busy           = busy_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized fetch sequences checked against a transaction-level buffer/memory model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        FetchStart;
   logic [7:0]  CurrentPC;
   logic        Invalidate;
   logic        MemReadValid;
   logic [7:0]  MemReadAddress;
   logic        MemReadReady;
   logic [15:0] MemReadData;
   logic [15:0] Instruction;
   logic        FetchDone;
   logic        Busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [256];
   bit          bv;
   logic [7:0]  bpc;
   logic [15:0] exp_instr;

   pc_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .FetchStart     (FetchStart),
      .CurrentPC      (CurrentPC),
      .Invalidate     (Invalidate),
      .MemReadValid   (MemReadValid),
      .MemReadAddress (MemReadAddress),
      .MemReadReady   (MemReadReady),
      .MemReadData    (MemReadData),
      .Instruction    (Instruction),
      .FetchDone      (FetchDone),
      .Busy           (Busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input bit mrv, input bit chk_addr,
                             input logic [7:0] addr, input bit done,
                             input logic [15:0] instr, input bit busy);
      chk({tag, ".MemReadValid"}, 32'(MemReadValid), 32'(mrv));
      if (chk_addr) chk({tag, ".MemReadAddress"}, 32'(MemReadAddress), 32'(addr));
      chk({tag, ".FetchDone"}, 32'(FetchDone), 32'(done));
      chk({tag, ".Instruction"}, 32'(Instruction), 32'(instr));
      chk({tag, ".Busy"}, 32'(Busy), 32'(busy));
   endtask

   task automatic idle_cycle(input bit inv);
      FetchStart = 1'b0;
      Invalidate = inv;
      tick();
      if (inv) bv = 1'b0;
      Invalidate = 1'b0;
      expect_out("idle_cyc", 1'b0, 1'b0, 8'h00, 1'b0, exp_instr, 1'b0);
   endtask

   // One complete fetch transaction; the model decides hit/miss from its own buffer state.
   task automatic do_fetch(input logic [7:0] pc, input int waits, input bit inv_start,
                           input bit inv_fill, input bit noise);
      bit is_hit;
      is_hit = bv && (bpc == pc);
      FetchStart   = 1'b1;
      CurrentPC    = pc;
      Invalidate   = inv_start;
      MemReadReady = 1'b0;
      MemReadData  = 16'($urandom);
      tick();
      if (inv_start) bv = 1'b0;
      FetchStart = 1'b0;
      Invalidate = 1'b0;
      if (is_hit) begin
         exp_instr = mem[pc];
         expect_out("hit", 1'b0, 1'b0, 8'h00, 1'b1, exp_instr, 1'b1);
      end else begin
         for (int k = 0; k <= waits; k++) begin
            expect_out("req", 1'b1, 1'b1, pc, 1'b0, exp_instr, 1'b1);
            MemReadReady = (k == waits);
            MemReadData  = (k == waits) ? mem[pc] : 16'($urandom);
            FetchStart   = noise;
            CurrentPC    = 8'($urandom);
            Invalidate   = inv_fill && (k == waits);
            tick();
            if (k == waits) begin
               bv  = 1'b1;
               bpc = pc;
               if (inv_fill) bv = 1'b0;
            end
         end
         exp_instr = mem[pc];
         expect_out("fill", 1'b0, 1'b0, 8'h00, 1'b1, exp_instr, 1'b1);
      end
      MemReadReady = 1'b0;
      Invalidate   = 1'b0;
      FetchStart   = noise;
      CurrentPC    = 8'($urandom);
      tick();
      FetchStart = 1'b0;
      expect_out("after_done", 1'b0, 1'b0, 8'h00, 1'b0, exp_instr, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h05] = 16'hA1B2;
      bv = 1'b0; bpc = 8'h00; exp_instr = 16'h0000;

      reset = 1'b1; FetchStart = 1'b0; CurrentPC = 8'h00; Invalidate = 1'b0;
      MemReadReady = 1'b0; MemReadData = 16'h0000;
      tick();
      tick();
      expect_out("reset", 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) idle_cycle(1'b0);

      do_fetch(8'h05, 0, 1'b0, 1'b0, 1'b0);
      do_fetch(8'h10, 3, 1'b0, 1'b0, 1'b1);
      do_fetch(8'h10, 0, 1'b0, 1'b0, 1'b0);
      idle_cycle(1'b1);
      do_fetch(8'h10, 1, 1'b0, 1'b0, 1'b0);

      do_fetch(8'h20, 2, 1'b0, 1'b1, 1'b0);
      do_fetch(8'h20, 0, 1'b0, 1'b0, 1'b0);

      do_fetch(8'h40, 0, 1'b0, 1'b0, 1'b0);
      do_fetch(8'h40, 0, 1'b1, 1'b0, 1'b0);
      do_fetch(8'h40, 0, 1'b0, 1'b0, 1'b0);

      // Abandon a request with reset while REQUEST is waiting on memory.
      idle_cycle(1'b1);
      FetchStart = 1'b1; CurrentPC = 8'h30;
      tick();
      FetchStart = 1'b0;
      expect_out("rst_req", 1'b1, 1'b1, 8'h30, 1'b0, exp_instr, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      bv = 1'b0; bpc = 8'h00; exp_instr = 16'h0000;
      expect_out("rst_mid", 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
      reset = 1'b0;
      idle_cycle(1'b0);
      do_fetch(8'h30, 1, 1'b0, 1'b0, 1'b0);
      do_fetch(8'hFF, 0, 1'b0, 1'b0, 1'b0);
      do_fetch(8'hFF, 0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         logic [7:0] pc;
         case ($urandom_range(0, 3))
            0: pc = 8'h10;
            1: pc = 8'h11;
            2: pc = 8'hFF;
            default: pc = 8'($urandom);
         endcase
         do_fetch(pc, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) idle_cycle(1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction fetch unit that consumes the program counter and reads the instruction at that address from program memory through a valid/ready read port. It sits between the core's PC register/PC+1 path and the program memory controller. It keeps a one-entry buffer of the last fetched PC/instruction pair, so re-fetching the same PC completes without a memory transaction.

## Interface
- PC_WIDTH, 8, width of program counter and memory address
- INSTR_WIDTH, 16, width of one instruction word

- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- FetchStart  input  1  request a fetch of CurrentPC; sampled only in IDLE
- CurrentPC  input  PC_WIDTH  address to fetch; sampled on accepted FetchStart
- Invalidate  input  1  clears the buffer valid bit
- MemReadValid  output  1  read request to program memory
- MemReadAddress  output  PC_WIDTH  read address, stable while MemReadValid=1
- MemReadReady  input  1  memory has read data this cycle
- MemReadData  input  INSTR_WIDTH  read data, valid when MemReadReady=1
- Instruction  output  INSTR_WIDTH  fetched instruction, held until next fetch completes
- FetchDone  output  1  one-cycle pulse: Instruction now valid for the requested PC
- Busy  output  1  high in REQUEST and DONE states

## Operation
- States: IDLE, REQUEST, DONE.
- IDLE: FetchStart=0 -> stay. FetchStart=1 -> latch CurrentPC into ReqPC; if BufValid=1 and BufPC==CurrentPC (hit) -> DONE with Instruction<=BufInstr; else (miss) -> REQUEST.
- REQUEST: MemReadValid=1, MemReadAddress=ReqPC. MemReadReady=0 -> stay, outputs unchanged. MemReadReady=1 -> Instruction<=MemReadData, BufPC<=ReqPC, BufInstr<=MemReadData, BufValid<=1, go to DONE.
- DONE: FetchDone=1 for exactly this cycle; unconditionally -> IDLE.
- FetchStart outside IDLE is ignored (not queued).
- MemReadValid is never deasserted before MemReadReady is seen; address never changes mid-request.
- Invalidate=1: BufValid<=0 next cycle in any state. If Invalidate coincides with buffer fill in REQUEST, Invalidate wins (BufValid=0), but the fetch still completes and Instruction/FetchDone behave normally.
- Invalidate coinciding with FetchStart in IDLE: lookup uses current BufValid (hit possible); Invalidate still clears BufValid.
- Address arithmetic: no wrap logic needed; PC_WIDTH-bit addresses used as given (PC 0xFF valid for PC_WIDTH=8).
- reset: state<=IDLE, MemReadValid=0, MemReadAddress=0, Instruction=0, FetchDone=0, Busy=0, BufValid=0, BufPC=0, BufInstr=0. Reset mid-REQUEST abandons the request; MemReadValid low the cycle after reset is sampled.

## Timing
- All outputs registered or decoded from registered state; no combinational path from MemReadData to Instruction.
- Miss, zero-wait memory: FetchStart at cycle N -> MemReadValid=1 in N+1 (MemReadReady=1 in N+1) -> FetchDone=1 and Instruction valid in N+2 -> IDLE in N+3. Each memory wait cycle adds one.
- Hit: FetchStart at N -> FetchDone=1, Instruction valid at N+1 -> IDLE at N+2; MemReadValid stays 0.
- Minimum spacing of accepted FetchStart: 2 cycles (hit), 3 cycles (zero-wait miss).
- Instruction holds its value from FetchDone until the next FetchDone (or reset).

## Test plan
- Reset then idle: reset=1 for 2 cycles -> all outputs 0, MemReadValid never asserts with FetchStart=0.
- Zero-wait miss: PC=0x05, memory returns 0xA1B2 immediately -> MemReadAddress=0x05 for one cycle, FetchDone at N+2, Instruction=0xA1B2.
- Wait states: PC=0x10, MemReadReady delayed 3 cycles -> MemReadValid/MemReadAddress=0x10 stable 4 cycles, FetchDone at N+5; FetchStart pulses during REQUEST ignored.
- Hit and invalidate: fetch 0x10 (miss), fetch 0x10 again -> FetchDone at N+1, no MemReadValid; pulse Invalidate, fetch 0x10 -> memory request issued again.
- Invalidate during fill: assert Invalidate in the MemReadReady cycle of a miss for 0x20 -> FetchDone normal, Instruction correct, subsequent fetch of 0x20 is a miss.
- Reset mid-request: reset while in REQUEST for 0x30 -> next cycle MemReadValid=0, FetchDone=0, Instruction=0; following fetch of 0x30 is a miss; PC=0xFF fetch returns data at address 0xFF.
